// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and imem write port of the boot loader.
//   byte_valid/byte_data/byte_ready : byte stream into the loader.
//     A byte moves on a rising clk edge when byte_valid and byte_ready are
//     both 1. The source holds byte_data stable while byte_valid is 1 and
//     byte_ready is 0. byte_ready does not depend on byte_valid.
//   imem_we/imem_waddr/imem_wdata   : one-cycle word write strobe, word address, data.
// Modports: master = stream source / memory side, slave = the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 15
) ();
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Takes a length-prefixed little-endian byte image, packs it into 32-bit words,
// writes them at sequential word addresses and keeps the core held until the
// whole image is in memory.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : imem_loader_if.slave (byte stream in, imem write port out)
//   restart    : one-cycle pulse, starts a new load from DONE or ERR
//   core_hold  : 1 keeps the pipeline stalled
//   done       : image fully written (level)
//   error      : length exceeded DEPTH_WORDS (level)
//   checksum   : sum of written words mod 2**32
//   fsm_state  : current FSM state (0 LEN, 1 DATA, 2 DONE, 3 ERR)
module imem_loader #(
  parameter int DEPTH_WORDS = 'h6000,
  parameter int ADDR_W      = 15
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  input  logic          restart,
  output logic          core_hold,
  output logic          done,
  output logic          error,
  output logic [31:0]   checksum,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;

  state_t            state, state_nxt;
  logic [1:0]        lane_q;
  logic [23:0]       shift_q;   // first three bytes of the word being assembled
  logic [31:0]       len_q;
  logic [ADDR_W-1:0] idx_q;

  logic        fire;
  logic        lane_last;
  logic [31:0] assembled;       // full little-endian word once the 4th byte arrives
  logic        last_word;

  assign fire      = bus.byte_valid & bus.byte_ready;
  assign lane_last = (lane_q == 2'd3);
  assign assembled = {bus.byte_data, shift_q};
  assign last_word = ({{(32-ADDR_W){1'b0}}, idx_q} == (len_q - 32'd1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LEN;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN: begin
        if (fire && lane_last) begin
          if (assembled == 32'd0)                    state_nxt = S_DONE;
          else if (assembled > 32'(DEPTH_WORDS))     state_nxt = S_ERR;
          else                                       state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        // Leaving on the 4th byte of the last word: the write strobe of that
        // word is then issued while already in DONE.
        if (fire && lane_last && last_word) state_nxt = S_DONE;
      end
      S_DONE:  if (restart) state_nxt = S_LEN;
      S_ERR:   if (restart) state_nxt = S_LEN;
      default: state_nxt = S_LEN;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.byte_ready = ((state == S_LEN) || (state == S_DATA)) && !rst;
    fsm_state      = state;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q         <= 2'd0;
      shift_q        <= 24'd0;
      len_q          <= 32'd0;
      idx_q          <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_waddr <= '0;
      bus.imem_wdata <= 32'd0;
      core_hold      <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      checksum       <= 32'd0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        S_LEN: begin
          if (fire) begin
            shift_q <= {bus.byte_data, shift_q[23:8]};
            lane_q  <= lane_q + 2'd1;
            if (lane_last) begin
              len_q <= assembled;
              idx_q <= '0;
              if (assembled > 32'(DEPTH_WORDS)) error <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (fire) begin
            shift_q <= {bus.byte_data, shift_q[23:8]};
            lane_q  <= lane_q + 2'd1;
            if (lane_last) begin
              bus.imem_we    <= 1'b1;
              bus.imem_wdata <= assembled;
              bus.imem_waddr <= idx_q;
              idx_q          <= idx_q + 1'b1;
              checksum       <= checksum + assembled;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (restart) begin
            lane_q    <= 2'd0;
            shift_q   <= 24'd0;
            len_q     <= 32'd0;
            idx_q     <= '0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            checksum  <= 32'd0;
          end else if (state == S_DONE) begin
            // One cycle after entering DONE, so the final write has settled.
            done      <= 1'b1;
            core_hold <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int DEPTH = 'h600;
  localparam int AW    = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        restart;
  logic        core_hold, done, error;
  logic [31:0] checksum;
  logic [1:0]  fsm_state;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .restart   (restart),
    .core_hold (core_hold),
    .done      (done),
    .error     (error),
    .checksum  (checksum),
    .fsm_state (fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] exp_item;
  logic [31:0]    exp_sum;
  logic [AW-1:0]  last_waddr;

  // Scoreboard: every write strobe is popped against the expected queue
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.imem_we === 1'b1) begin
      we_cnt++;
      last_waddr = bus.imem_waddr;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%h data=%h exp none", bus.imem_waddr, bus.imem_wdata);
      end else begin
        exp_item = exp_q.pop_front();
        if ({bus.imem_waddr, bus.imem_wdata} !== exp_item) begin
          errors++;
          $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                   bus.imem_waddr, bus.imem_wdata, exp_item[AW+31:32], exp_item[31:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
    end
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_accept got ready=%b exp 1 within 50 cycles", bus.byte_ready);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic send_data(input int idx, input logic [31:0] w, input int maxgap);
    logic [AW-1:0] a;
    a = idx[AW-1:0];
    exp_q.push_back({a, w});
    exp_sum = exp_sum + w;
    send_word(w, maxgap);
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 20);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done got done=%b exp 1", name, done);
    end
  endtask

  task automatic restart_dut(input string name);
    go_idle();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checks++;
    if ({fsm_state, bus.byte_ready, core_hold, done, error} !== 6'b001100 || checksum !== 32'd0) begin
      errors++;
      $display("FAIL %s_restart got st=%0d rdy=%b hold=%b done=%b err=%b sum=%h exp st=0 rdy=1 hold=1 done=0 err=0 sum=0",
               name, fsm_state, bus.byte_ready, core_hold, done, error, checksum);
    end
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    restart = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.byte_ready, bus.imem_we, core_hold, done, error} !== 5'b00100 ||
        bus.imem_waddr !== '0 || bus.imem_wdata !== 32'd0 || checksum !== 32'd0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_values got rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h sum=%h st=%0d",
               bus.byte_ready, bus.imem_we, core_hold, done, error, bus.imem_waddr, bus.imem_wdata, checksum, fsm_state);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b exp 1", bus.byte_ready);
    end
  endtask

  task automatic test_basic();
    we_cnt = 0;
    exp_sum = 32'd0;
    send_word(32'd2, 0);
    send_data(0, 32'h0000_0013, 0);
    send_data(1, 32'h0010_0093, 0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    checks++;
    if ({bus.imem_we, done, core_hold} !== 3'b101) begin
      errors++;
      $display("FAIL basic_last_we got we=%b done=%b hold=%b exp we=1 done=0 hold=1", bus.imem_we, done, core_hold);
    end
    @(negedge clk);
    checks++;
    if ({bus.imem_we, done, core_hold} !== 3'b010) begin
      errors++;
      $display("FAIL basic_release got we=%b done=%b hold=%b exp we=0 done=1 hold=0", bus.imem_we, done, core_hold);
    end
    checks++;
    if (checksum !== 32'h0010_00A6) begin
      errors++;
      $display("FAIL basic_checksum got %h exp 001000a6", checksum);
    end
    checks++;
    if (we_cnt !== 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_we_count got %0d left=%0d exp 2 left=0", we_cnt, exp_q.size());
    end
    restart_dut("basic");
  endtask

  task automatic test_zero_len();
    we_cnt = 0;
    send_word(32'd0, 0);
    wait_done("zero");
    checks++;
    if (we_cnt !== 0 || core_hold !== 1'b0 || checksum !== 32'd0) begin
      errors++;
      $display("FAIL zero_len got we_cnt=%0d hold=%b sum=%h exp 0 0 0", we_cnt, core_hold, checksum);
    end
    restart_dut("zero");
  endtask

  task automatic test_error();
    we_cnt = 0;
    send_word(DEPTH + 1, 0);
    go_idle();
    checks++;
    if ({error, bus.byte_ready, core_hold, done} !== 4'b1010 || fsm_state !== 2'd3) begin
      errors++;
      $display("FAIL error_state got err=%b rdy=%b hold=%b done=%b st=%0d exp 1 0 1 0 st=3",
               error, bus.byte_ready, core_hold, done, fsm_state);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h5a;
    repeat (5) @(negedge clk);
    bus.byte_valid = 1'b0;
    checks++;
    if (we_cnt !== 0 || fsm_state !== 2'd3 || error !== 1'b1) begin
      errors++;
      $display("FAIL error_hold got we_cnt=%0d st=%0d err=%b exp 0 3 1", we_cnt, fsm_state, error);
    end
    restart_dut("error");
  endtask

  task automatic test_gaps();
    we_cnt = 0;
    exp_sum = 32'd0;
    send_word(32'd3, 5);
    send_data(0, $urandom, 5);
    // restart must be ignored while loading
    go_idle();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    send_data(1, $urandom, 5);
    send_data(2, $urandom, 5);
    go_idle();
    wait_done("gaps");
    checks++;
    if (we_cnt !== 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gaps_we_count got %0d left=%0d exp 3 left=0", we_cnt, exp_q.size());
    end
    checks++;
    if (checksum !== exp_sum) begin
      errors++;
      $display("FAIL gaps_checksum got %h exp %h", checksum, exp_sum);
    end
    restart_dut("gaps");
  endtask

  task automatic test_rst_mid();
    logic [31:0] w;
    we_cnt = 0;
    exp_sum = 32'd0;
    send_word(32'd4, 0);
    send_data(0, 32'hcafe_f00d, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2;
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.byte_ready, bus.imem_we, core_hold, done, error} !== 5'b00100 ||
        bus.imem_waddr !== '0 || bus.imem_wdata !== 32'd0 || checksum !== 32'd0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_values got rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h sum=%h st=%0d",
               bus.byte_ready, bus.imem_we, core_hold, done, error, bus.imem_waddr, bus.imem_wdata, checksum, fsm_state);
    end
    @(negedge clk);
    rst = 1'b0;
    we_cnt = 0;
    exp_sum = 32'd0;
    w = $urandom;
    send_word(32'd1, 0);
    send_data(0, w, 0);
    go_idle();
    wait_done("rst_mid");
    checks++;
    if (we_cnt !== 1 || checksum !== w || exp_q.size() != 0 || core_hold !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_reload got we_cnt=%0d sum=%h hold=%b exp 1 %h 0", we_cnt, checksum, core_hold, w);
    end
    restart_dut("rst_mid");
  endtask

  task automatic test_full_depth();
    we_cnt = 0;
    exp_sum = 32'd0;
    send_word(DEPTH, 0);
    for (int i = 0; i < DEPTH; i++) send_data(i, $urandom, 0);
    go_idle();
    wait_done("full");
    checks++;
    if (error !== 1'b0 || we_cnt !== DEPTH || last_waddr !== AW'(DEPTH - 1)) begin
      errors++;
      $display("FAIL full_depth got err=%b we_cnt=%0d last=%h exp 0 %0d %h",
               error, we_cnt, last_waddr, DEPTH, AW'(DEPTH - 1));
    end
    checks++;
    if (checksum !== exp_sum) begin
      errors++;
      $display("FAIL full_checksum got %h exp %h", checksum, exp_sum);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_error();
    test_gaps();
    test_rst_mid();
    test_full_depth();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
